// File: rtl/wf_rgb_framebuf_pkg.sv
// Shared types and constants for the double-buffered RGB framebuffer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package wf_rgb_framebuf_pkg;

  localparam int FB_ADDR_W = 6;
  localparam int FB_DEPTH  = 64;
  localparam int FB_PIX_W  = 16;
  localparam int ROW_W     = 3;

  // Pixel layout {1'b0, RED, GRN, BLUE}
  localparam int PIX_BLUE_LSB = 0;
  localparam int PIX_BLUE_MSB = 4;
  localparam int PIX_GRN_LSB  = 5;
  localparam int PIX_GRN_MSB  = 9;
  localparam int PIX_RED_LSB  = 10;
  localparam int PIX_RED_MSB  = 14;

  typedef logic [FB_ADDR_W-1:0] fb_addr_t;
  typedef logic [FB_PIX_W-1:0]  fb_pix_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_CLEAR   = 2'd2
  } fb_state_t;

  function automatic fb_pix_t pix_pack(input logic [4:0] red,
                                       input logic [4:0] grn,
                                       input logic [4:0] blue);
    fb_pix_t p;
    p = '0;
    p[PIX_RED_MSB:PIX_RED_LSB]   = red;
    p[PIX_GRN_MSB:PIX_GRN_LSB]   = grn;
    p[PIX_BLUE_MSB:PIX_BLUE_LSB] = blue;
    return p;
  endfunction

endpackage

// File: rtl/wf_rgb_framebuf_if.sv
// Writer, swap-control and display-read signals of the framebuffer.
// Latency: n/a (wiring only).
// Backpressure: wr_ready gates the writer; commit is not queued while swap_pending.
interface wf_rgb_framebuf_if;
  import wf_rgb_framebuf_pkg::*;

  logic     wr_en;
  fb_addr_t wr_addr;
  fb_pix_t  wr_data;
  logic     wr_ready;
  logic     commit;
  logic     swap_pending;
  logic     frame_swapped;
  logic     scan_done;
  fb_addr_t rd_addr;
  fb_pix_t  rd_pixels;

  modport master (
    output wr_en, wr_addr, wr_data, commit, scan_done, rd_addr,
    input  wr_ready, swap_pending, frame_swapped, rd_pixels
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, commit, scan_done, rd_addr,
    output wr_ready, swap_pending, frame_swapped, rd_pixels
  );
endinterface

// File: rtl/wf_rgb_dpram.sv
// One 64x16 pixel bank: single write port, single registered read port.
// Latency: read data valid one clk after raddr.
// Backpressure: none; write happens whenever we is high.
module wf_rgb_dpram
  import wf_rgb_framebuf_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     we,
  input  fb_addr_t waddr,
  input  fb_pix_t  wdata,
  input  fb_addr_t raddr,
  output fb_pix_t  rdata
);

  fb_pix_t mem [FB_DEPTH];

  // Storage array; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port, cleared on reset so rd_pixels starts at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= '0;
    else     rdata <= mem[raddr];
  end

endmodule

// File: rtl/wf_rgb_framebuf.sv
// Double-buffered 8x8 RGB framebuffer; commit swaps front/back at the next frame end.
// Latency: rd_pixels one clk after rd_addr; swap at first frame end after commit.
// Backpressure: wr_ready low while a swap is pending (or back bank clearing); such writes drop.
// Optional feature macro WF_FB_CLEAR_ON_SWAP_EN: zero the new back bank after every swap.
module wf_rgb_framebuf
  import wf_rgb_framebuf_pkg::*;
#(
  parameter int SCAN_ROWS = 8
) (
  input logic              clk,
  input logic              rst,
  wf_rgb_framebuf_if.slave bus
);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SCAN_ROWS - 1);

  fb_state_t        state;
  fb_state_t        state_nxt;
  logic             bank_sel;
  logic             rd_sel;
  logic [ROW_W-1:0] row_cnt;
  logic             frame_end;
  logic             swap;
  logic             frame_swapped_q;
  logic             bank_we;
  fb_addr_t         bank_waddr;
  fb_pix_t          bank_wdata;
  fb_pix_t          q0;
  fb_pix_t          q1;

`ifdef WF_FB_CLEAR_ON_SWAP_EN
  fb_addr_t         clr_addr;
`endif

  assign frame_end = bus.scan_done && (row_cnt == ROW_LAST);

  // Row counter follows the display driver independently of swap state
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                row_cnt <= '0;
    else if (bus.scan_done) row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + 1'b1;
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state: a commit seen together with a frame end only arms the swap,
  // because PENDING is entered after that frame end has already passed
  always_comb begin
    state_nxt = state;
    swap      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.commit) state_nxt = ST_PENDING;
      end
      ST_PENDING: begin
        if (frame_end) begin
          swap = 1'b1;
`ifdef WF_FB_CLEAR_ON_SWAP_EN
          state_nxt = ST_CLEAR;
`else
          state_nxt = ST_IDLE;
`endif
        end
      end
`ifdef WF_FB_CLEAR_ON_SWAP_EN
      ST_CLEAR: begin
        if (clr_addr == fb_addr_t'(FB_DEPTH - 1)) state_nxt = ST_IDLE;
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

`ifdef WF_FB_CLEAR_ON_SWAP_EN
  // Clear sweep address: walks 0..63 while in CLEAR, parked at 0 otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    clr_addr <= '0;
    else if (state == ST_CLEAR) clr_addr <= clr_addr + 1'b1;
    else                        clr_addr <= '0;
  end
`endif

  // Bank select, swap pulse and read-side bank snapshot; rd_sel captures the
  // bank that was front when rd_addr was presented
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_sel        <= 1'b0;
      frame_swapped_q <= 1'b0;
      rd_sel          <= 1'b0;
    end else begin
      if (swap) bank_sel <= ~bank_sel;
      frame_swapped_q <= swap;
      rd_sel          <= bank_sel;
    end
  end

  // Back-bank write source: writer in IDLE, zero sweep in CLEAR
  always_comb begin
    bank_we    = bus.wr_en && (state == ST_IDLE);
    bank_waddr = bus.wr_addr;
    bank_wdata = bus.wr_data;
`ifdef WF_FB_CLEAR_ON_SWAP_EN
    if (state == ST_CLEAR) begin
      bank_we    = 1'b1;
      bank_waddr = clr_addr;
      bank_wdata = '0;
    end
`endif
  end

  wf_rgb_dpram u_bank0 (
    .clk   (clk),
    .rst   (rst),
    .we    (bank_we && bank_sel),
    .waddr (bank_waddr),
    .wdata (bank_wdata),
    .raddr (bus.rd_addr),
    .rdata (q0)
  );

  wf_rgb_dpram u_bank1 (
    .clk   (clk),
    .rst   (rst),
    .we    (bank_we && !bank_sel),
    .waddr (bank_waddr),
    .wdata (bank_wdata),
    .raddr (bus.rd_addr),
    .rdata (q1)
  );

  assign bus.wr_ready      = (state == ST_IDLE);
  assign bus.swap_pending  = (state == ST_PENDING);
  assign bus.frame_swapped = frame_swapped_q;
  assign bus.rd_pixels     = rd_sel ? q1 : q0;

endmodule

// File: tb/tb_wf_rgb_framebuf.sv
// Self-checking bench for wf_rgb_framebuf: table-driven pixel writes/reads with a
// read scoreboard, plus hand-written swap timing, drop, double-commit and reset sequences.
// Honours WF_FB_CLEAR_ON_SWAP_EN for the back-bank clear behaviour.
module tb_wf_rgb_framebuf;
  import wf_rgb_framebuf_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wf_rgb_framebuf_if bus ();

  wf_rgb_framebuf #(.SCAN_ROWS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [5:0]  addr;
    logic [15:0] data;  // written to the back bank, expected back after the swap
  } vec_t;

  vec_t        vecs [8];
  int          checks   = 0;
  int          failures = 0;
  int          fs_cnt   = 0;
  int          fs0;
  logic [15:0] mdl   [2][64];
  bit          known [2][64];
  int          mdl_sel = 0;
  logic [15:0] exp_q [$];
  bit          rd_req = 0;
`ifdef WF_FB_CLEAR_ON_SWAP_EN
  bit          clr_act = 0;
  int          clr_len = 0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one clock, sample 1ns after the edge, retire any read, clear pulses
  task automatic cyc();
    logic [15:0] e;
    @(posedge clk);
    #1;
    if (bus.frame_swapped === 1'b1) fs_cnt++;
    if (rd_req) begin
      e = exp_q.pop_front();
      chk("rd_pixels", {16'h0, bus.rd_pixels}, {16'h0, e});
      rd_req = 0;
    end
`ifdef WF_FB_CLEAR_ON_SWAP_EN
    if (bus.frame_swapped === 1'b1) begin
      clr_act = 1;
      clr_len = 0;
    end
    if (clr_act) begin
      if (bus.wr_ready === 1'b1) begin
        chk("clear_len", clr_len, 64);
        clr_act = 0;
      end else begin
        clr_len++;
      end
    end
`endif
    bus.wr_en     = 1'b0;
    bus.commit    = 1'b0;
    bus.scan_done = 1'b0;
  endtask

  task automatic read_issue(input logic [5:0] a);
    bus.rd_addr = a;
    exp_q.push_back(mdl[mdl_sel][a]);
    rd_req = 1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [15:0] d, input bit accept);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    if (accept) begin
      mdl[1 - mdl_sel][a]   = d;
      known[1 - mdl_sel][a] = 1;
    end
  endtask

  task automatic mdl_swap();
    mdl_sel = 1 - mdl_sel;
`ifdef WF_FB_CLEAR_ON_SWAP_EN
    for (int i = 0; i < 64; i++) begin
      mdl[1 - mdl_sel][i]   = 16'h0;
      known[1 - mdl_sel][i] = 1;
    end
`endif
  endtask

  task automatic settle();
`ifdef WF_FB_CLEAR_ON_SWAP_EN
    repeat (70) cyc();
`else
    cyc();
`endif
    chk("fs_one_cycle", bus.frame_swapped, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{6'd5,  16'h7FFF};
    vecs[1] = '{6'd0,  16'h0001};
    vecs[2] = '{6'd63, pix_pack(5'h1F, 5'h00, 5'h00)};
    vecs[3] = '{6'd1,  16'h03E0};
    vecs[4] = '{6'd2,  16'h001F};
    vecs[5] = '{6'd10, 16'h5555};
    vecs[6] = '{6'd20, 16'h2AAA};
    vecs[7] = '{6'd62, 16'h4210};

    bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.commit = 0; bus.scan_done = 0; bus.rd_addr = '0;
    rst = 1'b1;
    repeat (3) cyc();
    chk("rst_wr_ready",      bus.wr_ready, 1);
    chk("rst_swap_pending",  bus.swap_pending, 0);
    chk("rst_frame_swapped", bus.frame_swapped, 0);
    chk("rst_rd_pixels",     bus.rd_pixels, 0);
    rst = 1'b0;
    cyc();

    // Table writes into back bank; last write shares its cycle with commit
    for (int i = 0; i < 8; i++) begin
      chk("wr_ready_idle", bus.wr_ready, 1);
      wr(vecs[i].addr, vecs[i].data, 1);
      if (i == 7) bus.commit = 1'b1;
      cyc();
    end
    chk("pending_after_commit", bus.swap_pending, 1);
    chk("wr_ready_pending", bus.wr_ready, 0);

    // Swap lands on the cycle after the 8th scan_done
    for (int i = 0; i < 8; i++) begin
      bus.scan_done = 1'b1;
      cyc();
      chk("fs_timing_first", bus.frame_swapped, (i == 7));
    end
    chk("pending_cleared", bus.swap_pending, 0);
    mdl_swap();
    settle();

    // Table readback through scoreboard, back-to-back reads
    for (int i = 0; i < 8; i++) begin
      read_issue(vecs[i].addr);
      cyc();
    end

    // Dropped write in PENDING, second commit ignored, swap-cycle read ordering
    wr(6'd3, 16'h1234, 1);
    cyc();
    bus.commit = 1'b1;
    cyc();
    chk("wr_ready_pending2", bus.wr_ready, 0);
    wr(6'd3, 16'h001F, 0);
    bus.commit = 1'b1;
    cyc();
    chk("pending_held", bus.swap_pending, 1);
    fs0 = fs_cnt;
    for (int i = 0; i < 8; i++) begin
      bus.scan_done = 1'b1;
      if (i == 7) read_issue(vecs[0].addr);
      cyc();
    end
    mdl_swap();
    read_issue(6'd3);
    cyc();
    settle();
    repeat (10) cyc();
    chk("single_swap", fs_cnt - fs0, 1);

    // Commit coinciding with a frame end waits a whole further frame
    for (int i = 0; i < 16; i++) begin
      bus.scan_done = 1'b1;
      if (i == 7) bus.commit = 1'b1;
      cyc();
      chk("late_commit_pending", bus.swap_pending, (i >= 7 && i < 15));
      chk("late_commit_fs", bus.frame_swapped, (i == 15));
    end
    mdl_swap();
    settle();

    // Reset mid-PENDING abandons the swap
    bus.commit = 1'b1;
    cyc();
    fs0 = fs_cnt;
    for (int i = 0; i < 4; i++) begin
      bus.scan_done = 1'b1;
      cyc();
    end
    rst = 1'b1;
    #1;
    chk("rst_mid_pending", bus.swap_pending, 0);
    chk("rst_mid_wr_ready", bus.wr_ready, 1);
    cyc();
    rst = 1'b0;
    mdl_sel = 0;
    chk("rst_no_swap", fs_cnt - fs0, 0);
    read_issue(6'd3);
    cyc();

    // Row counter restarted at zero: swap after exactly 8 more pulses
    bus.commit = 1'b1;
    cyc();
    for (int i = 0; i < 8; i++) begin
      bus.scan_done = 1'b1;
      cyc();
      chk("fs_after_rst", bus.frame_swapped, (i == 7));
    end
    mdl_swap();
    settle();

    // Sweep every front address whose content the model knows
    for (int i = 0; i < 64; i++) begin
      if (known[mdl_sel][i]) begin
        read_issue(6'(i));
        cyc();
      end
    end
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
